// File: rtl/sram_like_arbiter.sv
// Two-requester arbiter onto one SRAM-like port: round-robin grant with an address-phase lock,
// and an owner FIFO that routes in-order data_ok/rdata back to whichever requester issued each access.
module sram_like_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,

    output logic        busy,
    output logic        err
);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [MAX_OUT-1:0] order_q, order_d;

    logic fifo_full;
    logic fifo_empty;
    logic grant_req;
    logic push;
    logic pop;
    logic head;

    // A locked grant is frozen until its address handshake; otherwise round-robin, holding when idle.
    always_comb begin
        grant_d = grant_q;
        if (lock_q) begin
            grant_d = grant_q;
        end else if (m0_req && m1_req) begin
            grant_d = ~last_q;
        end else if (m0_req) begin
            grant_d = 1'b0;
        end else if (m1_req) begin
            grant_d = 1'b1;
        end
    end

    assign fifo_full  = (count_q == CNT_W'(MAX_OUT));
    assign fifo_empty = (count_q == '0);
    assign grant_req  = grant_d ? m1_req : m0_req;
    assign s_req      = rst && grant_req && !fifo_full;
    assign push       = s_req && s_addr_ok;
    assign pop        = rst && s_data_ok && !fifo_empty;
    assign head       = order_q[rd_ptr_q];

    assign s_wr    = grant_d ? m1_wr    : m0_wr;
    assign s_size  = grant_d ? m1_size  : m0_size;
    assign s_addr  = grant_d ? m1_addr  : m0_addr;
    assign s_wdata = grant_d ? m1_wdata : m0_wdata;

    assign m0_addr_ok = push && !grant_d;
    assign m1_addr_ok = push &&  grant_d;
    assign m0_data_ok = pop  && !head;
    assign m1_data_ok = pop  &&  head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    assign busy = rst && !fifo_empty;
    assign err  = err_q;

    always_comb begin
        last_d   = last_q;
        lock_d   = lock_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        order_d  = order_q;

        if (push) begin
            order_d[wr_ptr_q] = grant_d;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            last_d            = grant_d;
            lock_d            = 1'b0;
        end else if (s_req) begin
            lock_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A response with nothing outstanding has no owner; flag it and leave the FIFO alone.
        if (s_data_ok && fifo_empty) begin
            err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            order_q  <= '0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            order_q  <= order_d;
        end
    end

endmodule
